// File: rtl/dcache_tag_arbiter_if.sv
// Request/SRAM bus of the data-cache tag arbiter: N request ports in, one
// winner-driven SRAM port out, plus tag read data and the compare results.
interface dcache_tag_arbiter_if #(
    parameter int NR_PORTS   = 4,
    parameter int NR_WAYS    = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int TAG_WIDTH  = 44,
    parameter int LINE_WIDTH = 128
);
    localparam int BE_W  = LINE_WIDTH / 8;
    localparam int IDX_W = (NR_WAYS > 1) ? $clog2(NR_WAYS) : 1;

    logic [NR_PORTS-1:0][NR_WAYS-1:0]    req_i;
    logic [NR_PORTS-1:0]                 gnt_o;
    logic [NR_PORTS-1:0][ADDR_WIDTH-1:0] addr_i;
    logic [NR_PORTS-1:0]                 we_i;
    logic [NR_PORTS-1:0][LINE_WIDTH-1:0] wdata_i;
    logic [NR_PORTS-1:0][BE_W-1:0]       be_i;
    logic [NR_PORTS-1:0][TAG_WIDTH-1:0]  tag_i;
    logic [NR_WAYS-1:0]                  req_o;
    logic [ADDR_WIDTH-1:0]               addr_o;
    logic                                we_o;
    logic [LINE_WIDTH-1:0]               wdata_o;
    logic [BE_W-1:0]                     be_o;
    logic [NR_WAYS-1:0][TAG_WIDTH-1:0]   rdata_tag_i;
    logic [NR_WAYS-1:0]                  rdata_valid_i;
    logic [NR_PORTS-1:0]                 sel_port_o;
    logic [NR_WAYS-1:0]                  hit_way_o;
    logic                                hit_o;
    logic [IDX_W-1:0]                    hit_idx_o;
    logic                                multi_hit_o;
    logic                                multi_hit_err_o;

    modport slave (
        input  req_i, addr_i, we_i, wdata_i, be_i, tag_i, rdata_tag_i, rdata_valid_i,
        output gnt_o, req_o, addr_o, we_o, wdata_o, be_o,
        output sel_port_o, hit_way_o, hit_o, hit_idx_o, multi_hit_o, multi_hit_err_o
    );

    modport master (
        output req_i, addr_i, we_i, wdata_i, be_i, tag_i, rdata_tag_i, rdata_valid_i,
        input  gnt_o, req_o, addr_o, we_o, wdata_o, be_o,
        input  sel_port_o, hit_way_o, hit_o, hit_idx_o, multi_hit_o, multi_hit_err_o
    );
endinterface

// File: rtl/dcache_tag_arbiter.sv
// Single-winner arbiter (fixed priority with starvation promotion, or round-robin)
// in front of the tag/data SRAMs, with a one-cycle-later tag compare stage.
module dcache_tag_arbiter #(
    parameter int NR_PORTS     = 4,
    parameter int NR_WAYS      = 8,
    parameter int ADDR_WIDTH   = 12,
    parameter int TAG_WIDTH    = 44,
    parameter int LINE_WIDTH   = 128,
    parameter int RR_MODE      = 0,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    dcache_tag_arbiter_if.slave  bus
);
    localparam int PW    = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam int BE_W  = LINE_WIDTH / 8;
    localparam int IDX_W = (NR_WAYS > 1) ? $clog2(NR_WAYS) : 1;

    logic [NR_PORTS-1:0]            active;
    logic                           win_vld;
    logic [PW-1:0]                  win_idx;
    logic [PW-1:0]                  cand;
    logic [NR_PORTS-1:0]            gnt;
    logic                           we_win;
    logic [PW-1:0]                  rr_q, rr_d;
    logic [NR_PORTS-1:0][CNT_W-1:0] starve_q, starve_d;
    logic [NR_PORTS-1:0]            id_q;
    logic                           rd_q;
    logic                           err_q;
    logic [TAG_WIDTH-1:0]           sel_tag;
    logic [NR_WAYS-1:0]             hit_way;
    logic [IDX_W-1:0]               hit_idx;
    logic                           multi_hit;

    always_comb begin
        for (int p = 0; p < NR_PORTS; p++) active[p] = |bus.req_i[p];
    end

    // Winner selection: RR searches upward from rr_q; fixed mode lets the
    // lowest starved requester pre-empt plain lowest-index priority.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        if (RR_MODE != 0) begin
            for (int i = 0; i < NR_PORTS; i++) begin
                cand = PW'((int'(rr_q) + i) % NR_PORTS);
                if (!win_vld && active[cand]) begin
                    win_vld = 1'b1;
                    win_idx = cand;
                end
            end
        end else begin
            for (int p = 0; p < NR_PORTS; p++) begin
                if (!win_vld && active[p] && starve_q[p] == CNT_W'(STARVE_LIMIT)) begin
                    win_vld = 1'b1;
                    win_idx = PW'(p);
                end
            end
            for (int p = 0; p < NR_PORTS; p++) begin
                if (!win_vld && active[p]) begin
                    win_vld = 1'b1;
                    win_idx = PW'(p);
                end
            end
        end
    end

    always_comb begin
        gnt         = '0;
        bus.req_o   = '0;
        bus.addr_o  = '0;
        we_win      = 1'b0;
        bus.wdata_o = '0;
        bus.be_o    = '0;
        if (win_vld) begin
            gnt[win_idx] = 1'b1;
            bus.req_o    = bus.req_i[win_idx];
            bus.addr_o   = bus.addr_i[win_idx];
            we_win       = bus.we_i[win_idx];
            bus.wdata_o  = bus.wdata_i[win_idx];
            bus.be_o     = bus.be_i[win_idx];
        end
    end

    assign bus.gnt_o = gnt;
    assign bus.we_o  = we_win;

    always_comb begin
        rr_d = rr_q;
        if (RR_MODE != 0 && win_vld) begin
            if (win_idx == PW'(NR_PORTS - 1)) rr_d = '0;
            else                              rr_d = win_idx + 1'b1;
        end
    end

    always_comb begin
        starve_d = '0;
        for (int p = 0; p < NR_PORTS; p++) begin
            if (RR_MODE == 0 && active[p] && !gnt[p]) begin
                if (starve_q[p] == CNT_W'(STARVE_LIMIT)) starve_d[p] = starve_q[p];
                else                                     starve_d[p] = starve_q[p] + 1'b1;
            end
        end
    end

    // Registered stage: remember who won and whether its access was a read.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_q     <= '0;
            rd_q     <= 1'b0;
            rr_q     <= '0;
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            id_q     <= gnt;
            rd_q     <= win_vld & ~we_win;
            rr_q     <= rr_d;
            starve_q <= starve_d;
            err_q    <= err_q | multi_hit;
        end
    end

    // Compare stage: tag of the registered winner against every way.
    always_comb begin
        sel_tag = '0;
        for (int p = 0; p < NR_PORTS; p++) begin
            if (id_q[p]) sel_tag = bus.tag_i[p];
        end
        for (int w = 0; w < NR_WAYS; w++) begin
            hit_way[w] = rd_q & bus.rdata_valid_i[w] & (bus.rdata_tag_i[w] == sel_tag);
        end
        hit_idx = '0;
        for (int w = NR_WAYS - 1; w >= 0; w--) begin
            if (hit_way[w]) hit_idx = IDX_W'(w);
        end
        multi_hit = ($countones(hit_way) > 1);
    end

    assign bus.sel_port_o      = id_q;
    assign bus.hit_way_o       = hit_way;
    assign bus.hit_o           = |hit_way;
    assign bus.hit_idx_o       = hit_idx;
    assign bus.multi_hit_o     = multi_hit;
    assign bus.multi_hit_err_o = err_q | multi_hit;
endmodule

// File: tb/tb_dcache_tag_arbiter.sv
// Bench for dcache_tag_arbiter: a fixed-priority and a round-robin instance share
// stimulus; a queue-free behavioural model predicts every output each cycle.
module tb_dcache_tag_arbiter;
    localparam int NP = 4, NW = 8, AW = 12, TW = 44, LW = 128, LIM = 15;

    logic clk = 1'b0;
    logic rst_n;
    logic cmp_en = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic [NP-1:0][NW-1:0]  req;
    logic [NP-1:0][AW-1:0]  addr;
    logic [NP-1:0]          we;
    logic [NP-1:0][LW-1:0]  wdata;
    logic [NP-1:0][LW/8-1:0] be;
    logic [NP-1:0][TW-1:0]  tag;
    logic [NW-1:0][TW-1:0]  rtag;
    logic [NW-1:0]          rvalid;

    always #5 clk = ~clk;

    dcache_tag_arbiter_if #(.NR_PORTS(NP), .NR_WAYS(NW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .LINE_WIDTH(LW)) bus_fp ();
    dcache_tag_arbiter_if #(.NR_PORTS(NP), .NR_WAYS(NW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .LINE_WIDTH(LW)) bus_rr ();

    dcache_tag_arbiter #(.NR_PORTS(NP), .NR_WAYS(NW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW),
                         .LINE_WIDTH(LW), .RR_MODE(0), .STARVE_LIMIT(LIM))
        dut_fp (.clk_i(clk), .rst_ni(rst_n), .bus(bus_fp));
    dcache_tag_arbiter #(.NR_PORTS(NP), .NR_WAYS(NW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW),
                         .LINE_WIDTH(LW), .RR_MODE(1), .STARVE_LIMIT(LIM))
        dut_rr (.clk_i(clk), .rst_ni(rst_n), .bus(bus_rr));

    assign bus_fp.req_i = req;   assign bus_rr.req_i = req;
    assign bus_fp.addr_i = addr; assign bus_rr.addr_i = addr;
    assign bus_fp.we_i = we;     assign bus_rr.we_i = we;
    assign bus_fp.wdata_i = wdata; assign bus_rr.wdata_i = wdata;
    assign bus_fp.be_i = be;     assign bus_rr.be_i = be;
    assign bus_fp.tag_i = tag;   assign bus_rr.tag_i = tag;
    assign bus_fp.rdata_tag_i = rtag;     assign bus_rr.rdata_tag_i = rtag;
    assign bus_fp.rdata_valid_i = rvalid; assign bus_rr.rdata_valid_i = rvalid;

    // Actual outputs gathered per instance: index 0 = fixed, 1 = round-robin.
    logic [NP-1:0]   a_gnt[2], a_sel[2];
    logic [NW-1:0]   a_req[2], a_hw[2];
    logic [AW-1:0]   a_addr[2];
    logic [LW-1:0]   a_wdata[2];
    logic [LW/8-1:0] a_be[2];
    logic [2:0]      a_idx[2];
    logic            a_we[2], a_hit[2], a_mh[2], a_err[2];

    assign a_gnt[0] = bus_fp.gnt_o;   assign a_gnt[1] = bus_rr.gnt_o;
    assign a_sel[0] = bus_fp.sel_port_o; assign a_sel[1] = bus_rr.sel_port_o;
    assign a_req[0] = bus_fp.req_o;   assign a_req[1] = bus_rr.req_o;
    assign a_hw[0] = bus_fp.hit_way_o; assign a_hw[1] = bus_rr.hit_way_o;
    assign a_addr[0] = bus_fp.addr_o; assign a_addr[1] = bus_rr.addr_o;
    assign a_wdata[0] = bus_fp.wdata_o; assign a_wdata[1] = bus_rr.wdata_o;
    assign a_be[0] = bus_fp.be_o;     assign a_be[1] = bus_rr.be_o;
    assign a_idx[0] = bus_fp.hit_idx_o; assign a_idx[1] = bus_rr.hit_idx_o;
    assign a_we[0] = bus_fp.we_o;     assign a_we[1] = bus_rr.we_o;
    assign a_hit[0] = bus_fp.hit_o;   assign a_hit[1] = bus_rr.hit_o;
    assign a_mh[0] = bus_fp.multi_hit_o; assign a_mh[1] = bus_rr.multi_hit_o;
    assign a_err[0] = bus_fp.multi_hit_err_o; assign a_err[1] = bus_rr.multi_hit_err_o;

    // Behavioural model state: winner as a port number (-1 = none).
    int cnt[2][NP];
    int ptr[2];
    int mid[2];
    bit mrd[2];
    bit merr[2];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int p = 0; p < NP; p++) cnt[m][p] = 0;
            ptr[m] = 0; mid[m] = -1; mrd[m] = 1'b0; merr[m] = 1'b0;
        end
    endtask

    function automatic int model_win(int m);
        if (m == 1) begin
            for (int i = 0; i < NP; i++) if (req[(ptr[1] + i) % NP] != 0) return (ptr[1] + i) % NP;
            return -1;
        end
        for (int p = 0; p < NP; p++) if (req[p] != 0 && cnt[0][p] == LIM) return p;
        for (int p = 0; p < NP; p++) if (req[p] != 0) return p;
        return -1;
    endfunction

    function automatic logic [NW-1:0] model_hit(int m);
        logic [NW-1:0] h = '0;
        if (mid[m] < 0 || !mrd[m]) return h;
        for (int w = 0; w < NW; w++) h[w] = rvalid[w] && (rtag[w] == tag[mid[m]]);
        return h;
    endfunction

    function automatic int lowest(logic [NW-1:0] h);
        for (int w = 0; w < NW; w++) if (h[w]) return w;
        return 0;
    endfunction

    initial model_reset();

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else begin
            for (int m = 0; m < 2; m++) begin
                int w;
                logic [NW-1:0] h;
                w = model_win(m);
                h = model_hit(m);
                if ($countones(h) > 1) merr[m] = 1'b1;
                mid[m] = w;
                mrd[m] = (w >= 0) && !we[w];
                if (m == 1 && w >= 0) ptr[1] = (w + 1) % NP;
                if (m == 0)
                    for (int p = 0; p < NP; p++)
                        cnt[0][p] = (req[p] != 0 && p != w) ? ((cnt[0][p] < LIM) ? cnt[0][p] + 1 : LIM) : 0;
            end
        end
    end

    task automatic chk(input string nm, input int m, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d got=%0h expected=%0h", nm, m, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int m = 0; m < 2; m++) begin
                int w;
                logic [NW-1:0] h;
                w = model_win(m);
                h = model_hit(m);
                chk("gnt", m, 128'(a_gnt[m]), (w >= 0) ? 128'(1) << w : 128'(0));
                chk("req_o", m, 128'(a_req[m]), (w >= 0) ? 128'(req[w]) : 128'(0));
                chk("addr_o", m, 128'(a_addr[m]), (w >= 0) ? 128'(addr[w]) : 128'(0));
                chk("we_o", m, 128'(a_we[m]), (w >= 0) ? 128'(we[w]) : 128'(0));
                chk("wdata_o", m, a_wdata[m], (w >= 0) ? wdata[w] : 128'(0));
                chk("be_o", m, 128'(a_be[m]), (w >= 0) ? 128'(be[w]) : 128'(0));
                chk("sel_port", m, 128'(a_sel[m]), (mid[m] >= 0) ? 128'(1) << mid[m] : 128'(0));
                chk("hit_way", m, 128'(a_hw[m]), 128'(h));
                chk("hit", m, 128'(a_hit[m]), 128'(h != 0));
                chk("hit_idx", m, 128'(a_idx[m]), 128'(lowest(h)));
                chk("multi_hit", m, 128'(a_mh[m]), 128'($countones(h) > 1));
                chk("multi_err", m, 128'(a_err[m]), 128'(merr[m] || ($countones(h) > 1)));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req = '0; addr = '0; we = '0; wdata = '0; be = '0; tag = '0; rvalid = '0;
        for (int w = 0; w < NW; w++) rtag[w] = TW'(w + 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        tick(); tick();
        cmp_en = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_sel", 0, 128'(a_sel[0]), 128'(0));
        chk("rst_err", 1, 128'(a_err[1]), 128'(0));
        tick();

        // Fixed: ports 1 and 3 always requesting; port 3 promoted every 16th cycle.
        we = '1;
        req[1] = 8'h01; req[3] = 8'h80;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            chk("fp_starve_gnt", 0, 128'(a_gnt[0]), (c == 15 || c == 31) ? 128'h8 : 128'h2);
            chk("rr_13_gnt", 1, 128'(a_gnt[1]), (c % 2 == 0) ? 128'h2 : 128'h8);
            tick();
        end
        do_reset();

        // Round-robin over ports 0,1,3.
        req = '0; req[0] = 8'h3; req[1] = 8'h4; req[3] = 8'h10;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            chk("rr_seq_gnt", 1, 128'(a_gnt[1]), (c % 3 == 0) ? 128'h1 : (c % 3 == 1) ? 128'h2 : 128'h8);
            tick();
        end

        // Port 2 read granted, reset lands before the compare cycle.
        clear_inputs(); req[2] = 8'h20;
        @(negedge clk);
        chk("pre_rst_gnt", 1, 128'(a_gnt[1]), 128'h4);
        #1 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req = '0; req[1] = 8'h1; req[3] = 8'h1;
        tag[2] = 44'hABC; rtag[5] = 44'hABC; rvalid = '1;
        @(negedge clk);
        chk("post_rst_hit", 0, 128'(a_hit[0]), 128'(0));
        chk("post_rst_sel", 1, 128'(a_sel[1]), 128'(0));
        chk("post_rst_rr", 1, 128'(a_gnt[1]), 128'h2);
        tick();

        // Read hit on way 5 from port 2.
        clear_inputs(); req[2] = 8'h20;
        tick();
        req = '0; tag[2] = 44'hABC; rtag[5] = 44'hABC; rvalid = '1;
        @(negedge clk);
        chk("rd_hit_way", 0, 128'(a_hw[0]), 128'h20);
        chk("rd_hit", 0, 128'(a_hit[0]), 128'(1));
        chk("rd_hit_idx", 1, 128'(a_idx[1]), 128'(5));
        chk("rd_hit_sel", 1, 128'(a_sel[1]), 128'h4);
        tick();

        // Write with matching tag, then read whose matching way is invalid.
        clear_inputs(); req[0] = 8'h1; we[0] = 1'b1;
        tick();
        req = '0; we = '0; tag[0] = 44'hABC; rtag[5] = 44'hABC; rvalid = '1;
        @(negedge clk);
        chk("wr_no_hit", 0, 128'(a_hw[0]), 128'(0));
        tick();
        clear_inputs(); req[0] = 8'h1;
        tick();
        req = '0; tag[0] = 44'hABC; rtag[5] = 44'hABC; rvalid = 8'hDF;
        @(negedge clk);
        chk("inv_no_hit", 1, 128'(a_hw[1]), 128'(0));
        tick();

        // Multi-hit on ways 2 and 6, then sticky error until reset.
        clear_inputs(); req[1] = 8'h2;
        tick();
        req = '0; tag[1] = 44'h55; rtag[2] = 44'h55; rtag[6] = 44'h55; rvalid = '1;
        @(negedge clk);
        chk("mh_idx", 0, 128'(a_idx[0]), 128'(2));
        chk("mh_multi", 0, 128'(a_mh[0]), 128'(1));
        chk("mh_way", 1, 128'(a_hw[1]), 128'h44);
        tick();
        clear_inputs();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("mh_sticky", 0, 128'(a_err[0]), 128'(1));
            chk("mh_clean", 0, 128'(a_mh[0]), 128'(0));
            tick();
        end
        do_reset();
        @(negedge clk);
        chk("mh_cleared", 1, 128'(a_err[1]), 128'(0));
        tick();

        // Randomized traffic: fully random, then port 0 hogging to provoke starvation.
        for (int c = 0; c < 3000; c++) begin
            rst_n = 1'b1;
            for (int p = 0; p < NP; p++) begin
                if (c >= 1500 && p == 0) req[p] = 8'($urandom) | 8'h1;
                else if (c >= 1500) req[p] = ($urandom_range(0, 9) < 7) ? (8'($urandom) | 8'h1) : 8'h0;
                else req[p] = ($urandom_range(0, 2) == 0) ? 8'h0 : 8'($urandom);
                addr[p]  = AW'($urandom);
                we[p]    = 1'($urandom);
                wdata[p] = {$urandom, $urandom, $urandom, $urandom};
                be[p]    = 16'($urandom);
                tag[p]   = TW'($urandom_range(0, 3));
            end
            for (int w = 0; w < NW; w++) rtag[w] = TW'($urandom_range(0, 3));
            rvalid = 8'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
            end
            tick();
        end
        rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
